// File: rtl/seq_detect_01011010.sv
// Serial detector for the pattern 01011010 (first bit 0), with optional
// frame lock and per-bit checking enabled by defining SEQ_DET_LOCK_EN.
module seq_detect_01011010 #(
    parameter int CNT_W   = 8,
    parameter int ERR_THR = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_vld,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             locked,
    output logic             bit_err
);

    // Transmit order is MSB first: bit 7 is the first bit on the wire.
    localparam logic [7:0] PAT = 8'b01011010;

    // The error threshold must fit the 4-bit error-run register.
    if (ERR_THR < 1 || ERR_THR > 15) begin : g_bad_err_thr
        $error("ERR_THR must be within 1..15");
    end

    // K0..K7 count matched pattern bits; LK is the aligned state.
    typedef enum logic [3:0] {
        K0, K1, K2, K3, K4, K5, K6, K7, LK
    } state_t;

    state_t           state;
    state_t           hunt_nxt;
    logic             hunt_hit;
    logic [CNT_W-1:0] cnt_inc;

    // Overlap-aware hunt transitions; K7 falls back to K3 on a hit.
    always_comb begin
        hunt_nxt = K0;
        hunt_hit = 1'b0;
        case (state)
            K0: hunt_nxt = din ? K0 : K1;
            K1: hunt_nxt = din ? K2 : K1;
            K2: hunt_nxt = din ? K0 : K3;
            K3: hunt_nxt = din ? K4 : K1;
            K4: hunt_nxt = din ? K5 : K3;
            K5: hunt_nxt = din ? K0 : K6;
            K6: hunt_nxt = din ? K7 : K1;
            K7: begin
                hunt_nxt = din ? K0 : K3;
                hunt_hit = ~din;
            end
            default: hunt_nxt = K0;
        endcase
    end

    // Saturating increment of the match counter.
    always_comb begin
        if (match_cnt == {CNT_W{1'b1}}) begin
            cnt_inc = match_cnt;
        end else begin
            cnt_inc = match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef SEQ_DET_LOCK_EN
    localparam logic [3:0] THR = 4'(ERR_THR);

    logic [2:0] phase;
    logic [3:0] err_run;
    logic       frm_err;
    logic       exp_bit;
    logic       miss;
    logic       wrap;
    logic       frame_ok;
    logic       drop;

    // Per-bit checking against the expected pattern bit at this phase.
    always_comb begin
        exp_bit  = PAT[3'd7 - phase];
        miss     = din ^ exp_bit;
        wrap     = (phase == 3'd7);
        frame_ok = wrap & ~miss & ~frm_err;
        drop     = miss & (err_run == (THR - 4'd1));
    end
`else
    assign locked  = 1'b0;
    assign bit_err = 1'b0;
`endif

    // Main FSM: hunt, lock, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= K0;
            match     <= 1'b0;
            match_cnt <= '0;
`ifdef SEQ_DET_LOCK_EN
            locked    <= 1'b0;
            bit_err   <= 1'b0;
            phase     <= '0;
            err_run   <= '0;
            frm_err   <= 1'b0;
`endif
        end else if (!din_vld) begin
            match   <= 1'b0;
`ifdef SEQ_DET_LOCK_EN
            bit_err <= 1'b0;
`endif
        end
`ifdef SEQ_DET_LOCK_EN
        else if (state == LK) begin
            bit_err <= miss;
            match   <= frame_ok;
            if (frame_ok) begin
                match_cnt <= cnt_inc;
            end
            phase   <= phase + 3'd1;
            frm_err <= wrap ? 1'b0 : (frm_err | miss);
            if (drop) begin
                state   <= K0;
                locked  <= 1'b0;
                err_run <= '0;
            end else begin
                err_run <= miss ? (err_run + 4'd1) : 4'd0;
            end
        end
`endif
        else begin
            match <= hunt_hit;
            if (hunt_hit) begin
                match_cnt <= cnt_inc;
            end
`ifdef SEQ_DET_LOCK_EN
            bit_err <= 1'b0;
            if (hunt_hit) begin
                state   <= LK;
                locked  <= 1'b1;
                phase   <= '0;
                err_run <= '0;
                frm_err <= 1'b0;
            end else begin
                state <= hunt_nxt;
            end
`else
            state <= hunt_nxt;
`endif
        end
    end

endmodule
